mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one synchronous-read data memory port between two masters: M0 = CPU data
//  port (behind the bus decoder, mem_ren/mem_wen path), M1 = DMA/loader engine
//  (flash->program memory copies, USB buffers). M0 has fixed priority; M1 has
//  anti-starvation promotion and a bounded locked-burst mode. Read data returns
//  READ_LATENCY cycles after grant, steered to the master that issued it.
// PARAMETERS
//  ADDR_W        32  address width, both masters and memory
//  DATA_W        32  data width; byte strobes are DATA_W/8 wide
//  READ_LATENCY  1   memory read latency in cycles, legal 1..4
//  STARVE_LIMIT  4   consecutive M1 denials before M1 is promoted above M0
//  BURST_MAX     8   max consecutive locked M1 grants before one forced M0 slot
// PORTS
//  clk        in   1         system clock
//  reset      in   1         synchronous, active-high
//  m0_req     in   1         M0 access request, held until m0_gnt
//  m0_addr    in   ADDR_W    M0 byte address
//  m0_wen     in   1         1 = write, 0 = read
//  m0_wstrb   in   DATA_W/8  M0 byte enables (writes only)
//  m0_wdata   in   DATA_W    M0 write data
//  m0_gnt     out  1         M0 access accepted this cycle
//  m0_rvalid  out  1         M0 read data valid
//  m0_rdata   out  DATA_W    M0 read data
//  m1_*       -    -         same set as m0_* for M1
//  m1_lock    in   1         M1 requests to keep the port next cycle (burst)
//  mem_en     out  1         memory access strobe
//  mem_we     out  DATA_W/8  memory byte write enables (0 = read)
//  mem_addr   out  ADDR_W    memory address
//  mem_wdata  out  DATA_W    memory write data
//  mem_rdata  in   DATA_W    memory read data, READ_LATENCY after mem_en
// BEHAVIOUR
//  - Grant is combinational, same cycle as req; at most one gnt per cycle.
//    reset=1 forces m0_gnt=m1_gnt=mem_en=0, mem_we=0.
//  - Priority: M1 wins if (m1_req && (promote || locked)), else M0 wins if
//    m0_req, else M1 wins if m1_req. locked is overridden (M0 wins) when
//    burst_cnt==BURST_MAX && m0_req.
//  - mem_en=gnt_any; mem_addr/mem_wdata from winner; mem_we = wstrb if wen else 0.
//    Idle cycle: mem_addr/wdata = M0 values, mem_en=0.
//  - starve_cnt (reg): +1 when m1_req && !m1_gnt, saturates at STARVE_LIMIT;
//    cleared on m1_gnt or !m1_req. promote = (starve_cnt==STARVE_LIMIT).
//  - locked (reg): set to m1_lock on each m1_gnt; cleared on any cycle without
//    m1_gnt. burst_cnt: +1 per consecutive locked m1_gnt (sat BURST_MAX), cleared
//    on m0_gnt or !locked. After a forced M0 slot M1 lock restarts from 0.
//  - Writes complete at grant; no rvalid for writes.
//  - Read return: tag pipe, READ_LATENCY stages of {valid, master_id}, stage 0
//    loaded with {gnt_any && !wen_of_winner, winner}. Final stage drives
//    m0_rvalid/m1_rvalid; m0_rdata=m1_rdata=mem_rdata (qualified by rvalid).
//    One read may be issued every cycle; returns are in order, no stall path.
//  - Reset (any cycle, incl. mid-burst/outstanding reads): counters=0,
//    locked=0, tag pipe cleared -> outstanding reads produce no rvalid.
//  - Simultaneous m0_req/m1_req with starve_cnt<LIMIT and !locked: M0 wins.
// STRUCTURE
//  - Memory-map constants stay in config.vh; add MASTER_CPU=0, MASTER_DMA=1
//    localparams there for the tag encoding.
//  - One sub-module: rd_tag_pipe (parameterised depth shift register of
//    {valid,id}, sync reset). Grant logic and counters live in the top.
// TESTING
//  1 M0 read 0x100, M1 idle -> m0_gnt same cycle, m0_rvalid 1 cycle later,
//    m0_rdata=mem_rdata; m1_rvalid stays 0.
//  2 m0_req and m1_req held high continuously -> pattern M0,M0,M0,M0,M1 repeats
//    (STARVE_LIMIT=4); never two gnts in one cycle.
//  3 M1 locked burst of 12 writes, M0 requesting from cycle 3 -> 8 M1 grants,
//    1 M0 grant, then M1 resumes; mem_we=m1_wstrb on M1 write cycles.
//  4 Back-to-back reads M0@0x10, M1@0x20, M0@0x30 with READ_LATENCY=2 ->
//    rvalids M0,M1,M0 in consecutive cycles, 2 cycles after each grant.
//  5 reset asserted one cycle after M1 read grant -> no m1_rvalid ever,
//    counters 0, first post-reset simultaneous request grants M0.
//  6 M0 write 0xDEADBEEF wstrb=4'b0011 -> mem_we=4'b0011, mem_en=1, no rvalid.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data memory port arbiter.
package mem_port_arbiter_pkg;

  // Master identifiers carried in the read-return tag.
  typedef enum logic {
    MASTER_CPU = 1'b0,
    MASTER_DMA = 1'b1
  } master_e;

  // One stage of the read-return tag pipe.
  typedef struct packed {
    logic    valid;
    master_e id;
  } rd_tag_t;

  // Deepest memory read latency the tag pipe is meant to cover.
  localparam int READ_LATENCY_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Shift register of {valid, master id} that tracks reads in flight so that
// returning memory data can be steered to the master that issued the read.
module rd_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_i,
  input  logic id_i,
  output logic valid_o,
  output logic id_o
);

  rd_tag_t stage_q [DEPTH];

  // Advance the tags one stage per cycle; reset drops every read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= '{valid: valid_i, id: master_e'(id_i)};
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign valid_o = stage_q[DEPTH-1].valid;
  assign id_o    = stage_q[DEPTH-1].id;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single synchronous-read data memory port.
// M0 (CPU) has fixed priority; M1 (DMA) is promoted after repeated denials
// and may hold the port in a locked burst that is periodically broken for M0.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_wen,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_wen,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic                m1_lock,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int BURST_W  = $clog2(BURST_MAX + 1);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic                locked_q, locked_d;

  logic promote;
  logic burstFull;
  logic lockHold;
  logic m0Win;
  logic m1Win;
  logic gntAny;
  logic winWen;
  logic winId;
  logic issueRead;
  logic retValid;
  logic retId;

  assign promote   = (starve_q == STARVE_W'(STARVE_LIMIT));
  assign burstFull = (burst_q == BURST_W'(BURST_MAX));
  // A full burst gives up the lock only when M0 is actually waiting.
  assign lockHold  = locked_q && !(burstFull && m0_req);

  // Pick at most one winner this cycle; nobody wins while reset is held.
  always_comb begin
    m0Win = 1'b0;
    m1Win = 1'b0;
    if (!reset) begin
      if (m1_req && (promote || lockHold)) begin
        m1Win = 1'b1;
      end else if (m0_req) begin
        m0Win = 1'b1;
      end else if (m1_req) begin
        m1Win = 1'b1;
      end
    end
  end

  assign m0_gnt = m0Win;
  assign m1_gnt = m1Win;
  assign gntAny = m0Win || m1Win;

  // Steer the winning master onto the memory port; M0 values when idle.
  always_comb begin
    mem_addr  = m0_addr;
    mem_wdata = m0_wdata;
    mem_we    = '0;
    winWen    = m0_wen;
    winId     = MASTER_CPU;
    if (m1Win) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      winWen    = m1_wen;
      winId     = MASTER_DMA;
      if (m1_wen) begin
        mem_we = m1_wstrb;
      end
    end else if (m0Win && m0_wen) begin
      mem_we = m0_wstrb;
    end
  end

  assign mem_en    = gntAny;
  assign issueRead = gntAny && !winWen;

  // Next values of the starvation counter, lock flag and burst length.
  always_comb begin
    starve_d = '0;
    if (m1_req && !m1Win) begin
      starve_d = promote ? starve_q : starve_q + STARVE_W'(1);
    end
    locked_d = m1Win && m1_lock;
    burst_d  = '0;
    if (m1Win && m1_lock) begin
      burst_d = burstFull ? burst_q : burst_q + BURST_W'(1);
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      burst_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      burst_q  <= burst_d;
      locked_q <= locked_d;
    end
  end

  rd_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .valid_i (issueRead),
    .id_i    (winId),
    .valid_o (retValid),
    .id_o    (retId)
  );

  assign m0_rvalid = retValid && (retId == MASTER_CPU);
  assign m1_rvalid = retValid && (retId == MASTER_DMA);
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural memory and
// a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int LAT    = 2;
  localparam int STARVE = 4;
  localparam int BURST  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_wen, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [3:0]    m0_wstrb;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_wen, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [3:0]    m1_wstrb;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT),
    .STARVE_LIMIT(STARVE), .BURST_MAX(BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wstrb(m0_wstrb),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wstrb(m1_wstrb),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural synchronous-read memory with LAT cycles of read latency.
  logic [DW-1:0] memArr [logic [AW-1:0]];
  logic [DW-1:0] rdPipe [LAT];

  function automatic logic [DW-1:0] defPat(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) begin
    logic [DW-1:0] cur;
    cur = memArr.exists(mem_addr) ? memArr[mem_addr] : defPat(mem_addr);
    for (int i = LAT - 1; i > 0; i--) rdPipe[i] <= rdPipe[i-1];
    rdPipe[0] <= (mem_en && mem_we == 4'b0) ? cur : '0;
    if (mem_en && mem_we != 4'b0) begin
      for (int b = 0; b < 4; b++) if (mem_we[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
      memArr[mem_addr] = cur;
    end
  end
  assign mem_rdata = rdPipe[LAT-1];

  // Reference model: arbitration rules, memory contents, expected returns.
  typedef struct {
    int            due;
    bit            id;
    logic [DW-1:0] data;
  } ret_t;

  logic [DW-1:0] shadow [logic [AW-1:0]];
  ret_t          retQ[$];
  int            mStarve, mBurst, cyc;
  bit            mLocked;
  int            nChecks, nFails;
  int            expG;
  logic [8:0]    expCtl;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expWdata, expRdata;

  function automatic logic [DW-1:0] shadowRead(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : defPat(a);
  endfunction

  function automatic logic [8:0] obsCtl();
    return {m0_gnt, m1_gnt, mem_en, mem_we, m0_rvalid, m1_rvalid};
  endfunction

  task automatic predict();
    logic       wen;
    logic [3:0] strb, we;
    bit         rv0, rv1;
    if (reset) expG = 0;
    else if (m1_req && (mStarve == STARVE || (mLocked && !(mBurst == BURST && m0_req)))) expG = 2;
    else if (m0_req) expG = 1;
    else if (m1_req) expG = 2;
    else expG = 0;
    expAddr  = (expG == 2) ? m1_addr : m0_addr;
    expWdata = (expG == 2) ? m1_wdata : m0_wdata;
    wen      = (expG == 2) ? m1_wen : m0_wen;
    strb     = (expG == 2) ? m1_wstrb : m0_wstrb;
    we       = (expG != 0 && wen) ? strb : 4'b0;
    rv0 = 0; rv1 = 0; expRdata = '0;
    if (retQ.size() > 0 && retQ[0].due == cyc) begin
      if (retQ[0].id) rv1 = 1; else rv0 = 1;
      expRdata = retQ[0].data;
    end
    expCtl = {expG == 1, expG == 2, expG != 0, we, rv0, rv1};
  endtask

  task automatic toSample();
    predict();
    @(negedge clk);
  endtask

  task automatic commit();
    bit            nl;
    logic          wen;
    logic [3:0]    strb;
    logic [DW-1:0] cur;
    @(posedge clk);
    if (retQ.size() > 0 && retQ[0].due == cyc) void'(retQ.pop_front());
    if (reset) begin
      mStarve = 0; mBurst = 0; mLocked = 0;
      retQ.delete();
    end else begin
      if (m1_req && expG != 2) mStarve = (mStarve < STARVE) ? mStarve + 1 : STARVE;
      else mStarve = 0;
      nl = (expG == 2) && m1_lock;
      if (expG == 1 || !nl) mBurst = 0;
      else if (mBurst < BURST) mBurst = mBurst + 1;
      mLocked = nl;
      if (expG != 0) begin
        wen  = (expG == 2) ? m1_wen : m0_wen;
        strb = (expG == 2) ? m1_wstrb : m0_wstrb;
        cur  = shadowRead(expAddr);
        if (wen) begin
          for (int b = 0; b < 4; b++) if (strb[b]) cur[8*b +: 8] = expWdata[8*b +: 8];
          shadow[expAddr] = cur;
        end else begin
          retQ.push_back('{due: cyc + LAT, id: (expG == 2), data: cur});
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic setM0(input logic req, input logic [AW-1:0] addr, input logic wen,
                       input logic [3:0] strb, input logic [DW-1:0] wdata);
    m0_req = req; m0_addr = addr; m0_wen = wen; m0_wstrb = strb; m0_wdata = wdata;
  endtask

  task automatic setM1(input logic req, input logic lock, input logic [AW-1:0] addr,
                       input logic wen, input logic [3:0] strb, input logic [DW-1:0] wdata);
    m1_req = req; m1_lock = lock; m1_addr = addr; m1_wen = wen; m1_wstrb = strb; m1_wdata = wdata;
  endtask

  task automatic runIdle(input int n);
    m0_req = 0; m1_req = 0; m1_lock = 0;
    for (int i = 0; i < n; i++) begin
      toSample();
      commit();
    end
  endtask

  task automatic test_reset();
    reset = 1;
    setM0(1, 32'h104, 1, 4'hF, 32'h1111_2222);
    setM1(1, 1, 32'h204, 1, 4'hF, 32'h3333_4444);
    for (int i = 0; i < 2; i++) begin
      toSample();
      nChecks++;
      if (obsCtl() !== expCtl) begin
        nFails++; $display("[TB] FAIL reset_ctl cyc=%0d got %b expected %b", cyc, obsCtl(), expCtl);
      end
      nChecks++;
      if ({m0_gnt, m1_gnt, mem_en, mem_we} !== 7'b0) begin
        nFails++; $display("[TB] FAIL reset_gnt got %b expected 0", {m0_gnt, m1_gnt, mem_en, mem_we});
      end
      commit();
    end
    reset = 0;
    runIdle(1);
  endtask

  task automatic test_single_read();
    logic [DW-1:0] want;
    want = shadowRead(32'h100);
    setM0(1, 32'h100, 0, 4'h0, 32'h0);
    toSample();
    nChecks++;
    if (obsCtl() !== expCtl || m0_gnt !== 1'b1) begin
      nFails++; $display("[TB] FAIL single_read_gnt got %b expected %b", obsCtl(), expCtl);
    end
    commit();
    m0_req = 0;
    for (int k = 1; k <= LAT + 1; k++) begin
      toSample();
      nChecks++;
      if (obsCtl() !== expCtl || m1_rvalid !== 1'b0 || m0_rvalid !== (k == LAT)) begin
        nFails++; $display("[TB] FAIL single_read_rvalid k=%0d got %b expected %b", k, obsCtl(), expCtl);
      end
      if (k == LAT) begin
        nChecks++;
        if (m0_rdata !== want) begin
          nFails++; $display("[TB] FAIL single_read_data got %h expected %h", m0_rdata, want);
        end
      end
      commit();
    end
  endtask

  task automatic test_write();
    setM0(1, 32'h40, 1, 4'b0011, 32'hDEAD_BEEF);
    toSample();
    nChecks++;
    if (obsCtl() !== expCtl || mem_we !== 4'b0011 || mem_en !== 1'b1) begin
      nFails++; $display("[TB] FAIL write_we got %b expected %b", obsCtl(), expCtl);
    end
    nChecks++;
    if (mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF) begin
      nFails++; $display("[TB] FAIL write_bus got %h/%h expected 40/deadbeef", mem_addr, mem_wdata);
    end
    commit();
    m0_req = 0;
    for (int k = 1; k <= LAT + 1; k++) begin
      toSample();
      nChecks++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
        nFails++; $display("[TB] FAIL write_no_rvalid k=%0d got %b%b expected 00", k, m0_rvalid, m1_rvalid);
      end
      commit();
    end
  endtask

  task automatic test_starvation();
    setM0(1, 32'h200, 0, 4'h0, 32'h0);
    setM1(1, 0, 32'h300, 0, 4'h0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      toSample();
      nChecks++;
      if (obsCtl() !== expCtl) begin
        nFails++; $display("[TB] FAIL starve_ctl i=%0d got %b expected %b", i, obsCtl(), expCtl);
      end
      nChecks++;
      if ({m0_gnt, m1_gnt} !== ((i % 5 == 4) ? 2'b01 : 2'b10)) begin
        nFails++; $display("[TB] FAIL starve_pattern i=%0d got %b", i, {m0_gnt, m1_gnt});
      end
      commit();
    end
    runIdle(LAT + 1);
  endtask

  task automatic test_locked_burst();
    int m1Done, m1Before;
    bit m0Done, got0, got1;
    m1Done = 0; m1Before = 0; m0Done = 0;
    for (int i = 0; i < 40 && m1Done < 12; i++) begin
      setM0(i >= 3 && !m0Done, 32'h80, 0, 4'h0, 32'h0);
      setM1(1, m1Done < 11, 32'h400 + 32'(m1Done * 4), 1, 4'((m1Done % 15) + 1),
            32'hC0DE_0000 + 32'(m1Done));
      toSample();
      nChecks++;
      if (obsCtl() !== expCtl) begin
        nFails++; $display("[TB] FAIL burst_ctl i=%0d got %b expected %b", i, obsCtl(), expCtl);
      end
      nChecks++;
      if ({m0_gnt, m1_gnt} !== ((i == 8) ? 2'b10 : 2'b01)) begin
        nFails++; $display("[TB] FAIL burst_pattern i=%0d got %b", i, {m0_gnt, m1_gnt});
      end
      got0 = m0_gnt; got1 = m1_gnt;
      if (got1) begin
        nChecks++;
        if (mem_we !== m1_wstrb) begin
          nFails++; $display("[TB] FAIL burst_we i=%0d got %b expected %b", i, mem_we, m1_wstrb);
        end
      end
      commit();
      if (got1) begin
        m1Done++;
        if (!m0Done) m1Before++;
      end
      if (got0) m0Done = 1;
    end
    nChecks++;
    if (m1Done != 12 || m1Before != 8 || !m0Done) begin
      nFails++; $display("[TB] FAIL burst_counts got m1=%0d before=%0d m0=%0d expected 12/8/1",
                         m1Done, m1Before, m0Done);
    end
    runIdle(LAT + 1);
  endtask

  task automatic test_back_to_back();
    bit [5:0] m0rvTab, m1rvTab;
    m0rvTab = 6'b010100;
    m1rvTab = 6'b001000;
    for (int c = 0; c < 6; c++) begin
      setM0(c == 0 || c == 2, (c == 0) ? 32'h10 : 32'h30, 0, 4'h0, 32'h0);
      setM1(c == 1, 0, 32'h20, 0, 4'h0, 32'h0);
      toSample();
      nChecks++;
      if (obsCtl() !== expCtl) begin
        nFails++; $display("[TB] FAIL b2b_ctl c=%0d got %b expected %b", c, obsCtl(), expCtl);
      end
      nChecks++;
      if (m0_rvalid !== m0rvTab[c] || m1_rvalid !== m1rvTab[c]) begin
        nFails++; $display("[TB] FAIL b2b_rvalid c=%0d got %b%b expected %b%b",
                           c, m0_rvalid, m1_rvalid, m0rvTab[c], m1rvTab[c]);
      end
      if (expCtl[1:0] != 2'b00) begin
        nChecks++;
        if ((expCtl[1] ? m0_rdata : m1_rdata) !== expRdata) begin
          nFails++; $display("[TB] FAIL b2b_data c=%0d got %h expected %h",
                             c, expCtl[1] ? m0_rdata : m1_rdata, expRdata);
        end
      end
      commit();
    end
    runIdle(1);
  endtask

  task automatic test_reset_mid();
    setM0(1, 32'h700, 1, 4'hF, 32'h0);
    setM1(1, 0, 32'h704, 1, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      toSample();
      nChecks++;
      if (obsCtl() !== expCtl || m0_gnt !== 1'b1) begin
        nFails++; $display("[TB] FAIL rst_starve_pre i=%0d got %b expected %b", i, obsCtl(), expCtl);
      end
      commit();
    end
    reset = 1;
    toSample();
    nChecks++;
    if (obsCtl() !== expCtl) begin
      nFails++; $display("[TB] FAIL rst_starve_during got %b expected %b", obsCtl(), expCtl);
    end
    commit();
    reset = 0;
    toSample();
    nChecks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      nFails++; $display("[TB] FAIL rst_starve_after got %b expected 10", {m0_gnt, m1_gnt});
    end
    commit();
    runIdle(1);

    setM1(1, 1, 32'h500, 0, 4'h0, 32'h0);
    toSample();
    nChecks++;
    if (m1_gnt !== 1'b1) begin
      nFails++; $display("[TB] FAIL rst_mid_gnt got %b expected 1", m1_gnt);
    end
    commit();
    m1_req = 0;
    reset = 1;
    toSample();
    commit();
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      toSample();
      nChecks++;
      if (m1_rvalid !== 1'b0 || obsCtl() !== expCtl) begin
        nFails++; $display("[TB] FAIL rst_mid_rvalid k=%0d got %b expected %b", k, obsCtl(), expCtl);
      end
      commit();
    end
    setM0(1, 32'h504, 0, 4'h0, 32'h0);
    setM1(1, 1, 32'h508, 0, 4'h0, 32'h0);
    toSample();
    nChecks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      nFails++; $display("[TB] FAIL rst_mid_first got %b expected 10", {m0_gnt, m1_gnt});
    end
    commit();
    runIdle(LAT + 1);
  endtask

  task automatic test_random();
    bit m0Pend, m1Pend;
    m0Pend = 0; m1Pend = 0;
    for (int i = 0; i < 300; i++) begin
      if (!m0Pend && $urandom_range(0, 99) < 55) begin
        m0Pend = 1;
        setM0(1, 32'h600 + ($urandom_range(0, 15) << 2), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), $urandom);
      end
      if (!m1Pend && $urandom_range(0, 99) < 60) begin
        m1Pend = 1;
        setM1(1, 1'($urandom_range(0, 1)), 32'h600 + ($urandom_range(0, 15) << 2),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      end
      m0_req  = m0Pend;
      m1_req  = m1Pend;
      m1_lock = 1'($urandom_range(0, 3) != 0);
      toSample();
      nChecks++;
      if (obsCtl() !== expCtl) begin
        nFails++; $display("[TB] FAIL rand_ctl i=%0d got %b expected %b", i, obsCtl(), expCtl);
      end
      nChecks++;
      if ({mem_addr, mem_wdata} !== {expAddr, expWdata}) begin
        nFails++; $display("[TB] FAIL rand_bus i=%0d got %h/%h expected %h/%h",
                           i, mem_addr, mem_wdata, expAddr, expWdata);
      end
      if (expCtl[1:0] != 2'b00) begin
        nChecks++;
        if ((expCtl[1] ? m0_rdata : m1_rdata) !== expRdata) begin
          nFails++; $display("[TB] FAIL rand_data i=%0d got %h expected %h",
                             i, expCtl[1] ? m0_rdata : m1_rdata, expRdata);
        end
      end
      commit();
      if (expG == 1) m0Pend = 0;
      if (expG == 2) m1Pend = 0;
    end
    runIdle(LAT + 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    nChecks = 0; nFails = 0; cyc = 0;
    mStarve = 0; mBurst = 0; mLocked = 0;
    reset = 1;
    setM0(0, '0, 0, 4'h0, '0);
    setM1(0, 0, '0, 0, 4'h0, '0);
    @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_write();
    test_starvation();
    test_locked_burst();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
